// File: rtl/mem_sram_ctrl.sv
// MEM-stage bridge: splits each 32-bit load/store into two 16-bit accesses on an
// asynchronous SRAM and holds ready low while the access is in flight.
module mem_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memREn,
  input  logic        memWEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  output logic        sramDqOe,
  input  logic [15:0] sramDqIn,
  output logic        sramWeN
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [16:0] word_r;
  logic [31:0] data_r;
  logic        write_r;

  logic [18:0] reqOff_s;
  logic        lastCycle_s;

  // Only offset bits [18:2] reach the pins, so a 19-bit subtraction gives the same word.
  assign reqOff_s    = address[18:0] - BASE_ADDR[18:0];
  assign lastCycle_s = (cnt_r == CNT_LAST);

  // Request-to-ready is the single combinational path; everything on the SRAM side is registered.
  assign ready = (state_r == DONE) | ((state_r == IDLE) & ~memREn & ~memWEn);

  // Access sequencer: state, phase counter, latched request and SRAM pin registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      word_r    <= 17'd0;
      data_r    <= 32'd0;
      write_r   <= 1'b0;
      readData  <= 32'd0;
      sramAddr  <= 18'd0;
      sramDqOut <= 16'd0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (memREn | memWEn) begin
            state_r   <= LOW;
            cnt_r     <= 4'd0;
            word_r    <= reqOff_s[18:2];
            data_r    <= writeData;
            write_r   <= memWEn;
            sramAddr  <= {reqOff_s[18:2], 1'b0};
            sramDqOut <= writeData[15:0];
            sramDqOe  <= memWEn;
            sramWeN   <= ~memWEn;
          end else begin
            state_r <= IDLE;
          end
        end
        LOW: begin
          if (lastCycle_s) begin
            if (!write_r) begin
              readData[15:0] <= sramDqIn;
            end else begin
              readData[15:0] <= readData[15:0];
            end
            state_r   <= HIGH;
            cnt_r     <= 4'd0;
            sramAddr  <= {word_r, 1'b1};
            sramDqOut <= data_r[31:16];
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        HIGH: begin
          if (lastCycle_s) begin
            if (!write_r) begin
              readData[31:16] <= sramDqIn;
            end else begin
              readData[31:16] <= readData[31:16];
            end
            state_r  <= DONE;
            cnt_r    <= 4'd0;
            sramDqOe <= 1'b0;
            sramWeN  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          sramDqOe <= 1'b0;
          sramWeN  <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          sramDqOe <= 1'b0;
          sramWeN  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: a WAIT_CYCLES=5 instance for the main sequences
// and a WAIT_CYCLES=1 instance for back-to-back timing, each with its own SRAM array.
module tb_mem_sram_ctrl;

  localparam int WA = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        memREn = 1'b0, memWEn = 1'b0;
  logic [31:0] address = 32'd0, writeData = 32'd0, readData;
  logic        ready, sramDqOe, sramWeN;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;
  logic [15:0] memA [0:255];

  logic        memREnB = 1'b0, memWEnB = 1'b0;
  logic [31:0] addressB = 32'd0, writeDataB = 32'd0, readDataB;
  logic        readyB, sramDqOeB, sramWeNB;
  logic [17:0] sramAddrB;
  logic [15:0] sramDqOutB, sramDqInB;
  logic [15:0] memB [0:255];

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(WA)) dutA (
    .clk(clk), .rst(rst), .memREn(memREn), .memWEn(memWEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready), .sramAddr(sramAddr),
    .sramDqOut(sramDqOut), .sramDqOe(sramDqOe), .sramDqIn(sramDqIn), .sramWeN(sramWeN)
  );

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dutB (
    .clk(clk), .rst(rst), .memREn(memREnB), .memWEn(memWEnB), .address(addressB),
    .writeData(writeDataB), .readData(readDataB), .ready(readyB), .sramAddr(sramAddrB),
    .sramDqOut(sramDqOutB), .sramDqOe(sramDqOeB), .sramDqIn(sramDqInB), .sramWeN(sramWeNB)
  );

  assign sramDqIn  = memA[sramAddr[7:0]];
  assign sramDqInB = memB[sramAddrB[7:0]];

  // SRAM models: a halfword is written on any clock edge where WE# is low.
  always @(posedge clk) begin
    if (!sramWeN) memA[sramAddr[7:0]] <= sramDqOut;
    if (!sramWeNB) memB[sramAddrB[7:0]] <= sramDqOutB;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access on dutA, checking ready and every pin in each of the 2W+2 cycles.
  task automatic access(input string tag, input logic re, input logic we,
                        input logic [31:0] a, input logic [31:0] d, input logic disturb);
    logic [31:0] off;
    logic [17:0] baseA;
    logic        hi;
    off   = a - 32'd1024;
    baseA = {off[18:2], 1'b0};
    memREn = re; memWEn = we; address = a; writeData = d;
    for (int k = 0; k <= 2 * WA + 1; k++) begin
      @(negedge clk);
      checkVal({tag, "_ready"}, {31'd0, ready}, (k == 2 * WA + 1) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 2 * WA) begin
        hi = (k > WA);
        checkVal({tag, "_addr"}, {14'd0, sramAddr}, {14'd0, baseA | {17'd0, hi}});
        checkVal({tag, "_weN"}, {31'd0, sramWeN}, {31'd0, ~we});
        checkVal({tag, "_oe"}, {31'd0, sramDqOe}, {31'd0, we});
        if (we) checkVal({tag, "_dq"}, {16'd0, sramDqOut}, {16'd0, hi ? d[31:16] : d[15:0]});
      end else if (k == 2 * WA + 1) begin
        checkVal({tag, "_doneWeN"}, {31'd0, sramWeN}, 32'd1);
        checkVal({tag, "_doneOe"}, {31'd0, sramDqOe}, 32'd0);
      end
      if (k == 3 && disturb) begin
        memREn  = 1'b0;
        address = a + 32'h100;
      end
      @(posedge clk); #1;
    end
    memREn = 1'b0; memWEn = 1'b0;
  endtask

  initial begin
    logic       found;
    logic [7:0] rdyBits;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 16'd0;
      memB[i] = 16'd0;
    end

    // Reset held with a pending store request
    memWEn = 1'b1; address = 32'd1024; writeData = 32'd0;
    @(negedge clk);
    checkVal("rst_weN", {31'd0, sramWeN}, 32'd1);
    checkVal("rst_oe", {31'd0, sramDqOe}, 32'd0);
    checkVal("rst_readData", readData, 32'd0);
    checkVal("rst_addr", {14'd0, sramAddr}, 32'd0);
    checkVal("rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("rstRel_lowWeN", {31'd0, sramWeN}, 32'd0);
    checkVal("rstRel_lowAddr", {14'd0, sramAddr}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ready) found = 1'b1;
    end
    checkVal("rstRel_done", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
    memWEn = 1'b0;

    access("st", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    checkVal("st_mem4", {16'd0, memA[4]}, 32'h0000BEEF);
    checkVal("st_mem5", {16'd0, memA[5]}, 32'h0000DEAD);
    checkVal("st_readData", readData, 32'd0);

    access("ld", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    checkVal("ld_readData", readData, 32'hDEADBEEF);

    access("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    checkVal("both_mem0", {16'd0, memA[0]}, 32'h00005678);
    checkVal("both_mem1", {16'd0, memA[1]}, 32'h00001234);
    checkVal("both_readData", readData, 32'hDEADBEEF);

    access("dist", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);
    checkVal("dist_readData", readData, 32'h12345678);

    // Reset pulse during the HIGH phase of a store
    memWEn = 1'b1; address = 32'd1040; writeData = 32'hAAAA5555;
    for (int k = 0; k <= WA + 1; k++) @(negedge clk);
    checkVal("midRst_highAddr", {14'd0, sramAddr}, 32'd9);
    checkVal("midRst_highWeN", {31'd0, sramWeN}, 32'd0);
    #2 rst = 1'b0;
    #1;
    checkVal("midRst_weN", {31'd0, sramWeN}, 32'd1);
    checkVal("midRst_oe", {31'd0, sramDqOe}, 32'd0);
    checkVal("midRst_readData", readData, 32'd0);
    memWEn = 1'b0;
    #1;
    checkVal("midRst_idleReady", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("midRst_stayIdle", {31'd0, ready}, 32'd1);
    checkVal("midRst_stayWeN", {31'd0, sramWeN}, 32'd1);

    // WAIT_CYCLES=1: store then load back-to-back at 1028
    memWEnB = 1'b1; addressB = 32'd1028; writeDataB = 32'hCAFEF00D;
    rdyBits = 8'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rdyBits[c] = readyB;
      @(posedge clk); #1;
      if (c == 3) begin
        memWEnB = 1'b0; memREnB = 1'b1;
      end
    end
    memREnB = 1'b0;
    checkVal("w1_readyPattern", {24'd0, rdyBits}, 32'h00000088);
    checkVal("w1_mem2", {16'd0, memB[2]}, 32'h0000F00D);
    checkVal("w1_mem3", {16'd0, memB[3]}, 32'h0000CAFE);
    checkVal("w1_readData", readDataB, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
Memory-stage consumer of the EX/MEM pipeline outputs (memory read enable, memory write enable, ALU result as address, Rm value as store data).
- Converts each 32-bit load/store into two sequential 16-bit accesses on an external asynchronous SRAM.
- Drops ready while an access is in flight so the hazard/freeze logic stalls every pipeline register.
- Returns the 32-bit load word to the MEM/WB path.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM location 0; subtracted from the incoming address.
- WAIT_CYCLES, 5: cycles each 16-bit half-access is held on the SRAM pins; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- memREn  input  1  load request from EX/MEM.
- memWEn  input  1  store request from EX/MEM.
- address  input  32  byte address (ALU result).
- writeData  input  32  store data (Rm value).
- readData  output  32  load result.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sramAddr  output  18  SRAM halfword address.
- sramDqOut  output  16  SRAM write data.
- sramDqOe  output  1  SRAM data bus drive enable (tri-state at top level).
- sramDqIn  input  16  SRAM read data.
- sramWeN  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, latched addr/data 0, readData 0, sramAddr 0, sramDqOut 0, sramDqOe 0, sramWeN 1. Reset mid-access aborts immediately; sramWeN returns high without waiting for clk.
- Address translation: off = address - BASE_ADDR (32-bit, modulo 2^32); word = off[18:2]; sramAddr = {word, half} with half=0 for the low phase and 1 for the high phase. off[1:0] is ignored. Out-of-range addresses wrap; no error.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If memREn|memWEn: latch address, writeData and op (write if memWEn, else read), clear counter, go to LOW.
  - If both enables are set, the access is a write.
- LOW:
  - sramAddr = {word,0}.
  - Write: sramDqOe=1, sramWeN=0, sramDqOut = data[15:0].
  - Read: sramDqOe=0, sramWeN=1.
  - Counter increments each cycle. On the cycle counter==WAIT_CYCLES-1: a read captures sramDqIn into readData[15:0]; clear counter; go to HIGH.
- HIGH: same as LOW using {word,1}, data[31:16] and readData[31:16]; on completion go to DONE.
- DONE: SRAM pins idle (oe=0, weN=1), go to IDLE.
- ready = (state==DONE) | (state==IDLE & !memREn & !memWEn). This is the only combinational path from request inputs to an output. All SRAM pins are decoded from registered state only.
- Latency: request seen in IDLE at cycle t. LOW occupies t+1..t+W, HIGH occupies t+W+1..t+2W, DONE is t+2W+1. ready is low for 2W+1 cycles (11 at W=5) and high in DONE. EX/MEM advances on the DONE edge.
- Inputs changing or deasserting after the IDLE accept are ignored; the transaction always completes with the latched values.
- readData:
  - Updates only on read captures; a write leaves it unchanged.
  - Between the two captures the low half is new and the high half is old. It is only valid once ready is high.
- Back-to-back requests: IDLE after DONE accepts the next request immediately, so ready is high for exactly the one DONE cycle.

Test Plan:
- Reset: hold rst=0 with memWEn=1 → sramWeN=1, sramDqOe=0, readData=0, ready=0 (request pending in IDLE). Release rst → LOW entered on the next edge.
- Store: address=1024+8, writeData=0xDEADBEEF, memWEn=1.
  - Expected: sramAddr=0x4 with dq=0xBEEF and weN=0 for 5 cycles, then sramAddr=0x5 with dq=0xDEAD for 5 cycles.
  - ready low for 11 cycles, high on the 12th.
- Load: SRAM model holds 0xBEEF at 0x4 and 0xDEAD at 0x5; memREn=1, address=1032 → readData=0xDEADBEEF when ready rises, 11 cycles after the request; sramWeN stays 1 throughout.
- Both memREn=1 and memWEn=1, writeData=0x12345678, address=1024 → write to halfwords 0/1 occurs; readData unchanged.
- Mid-access disturbance: drop memREn and change address in cycle 3 of a load → access completes at the original address with the same 11-cycle timing. A second rst pulse during HIGH of a store immediately forces weN=1 and state IDLE.
- WAIT_CYCLES=1 build: back-to-back store then load at 1028 → each ready-low window is 3 cycles, and ready is high for a single cycle between them.
